// File: rtl/isb_pkg.sv
// Shared ISB definitions: per-entry state encoding, default widths and the
// prefetch-buffer entry record.
package isb_pkg;

  localparam int ISB_AW = 16;
  localparam int ISB_DW = 16;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_QUEUED  = 2'd1,
    ST_PENDING = 2'd2,
    ST_READY   = 2'd3
  } entry_state_e;

  typedef struct packed {
    entry_state_e              st;
    logic [ISB_AW-1:0]         addr;
    logic [ISB_DW-1:0]         data;
  } entry_t;

endpackage

// File: rtl/isb_pfb_pick.sv
// Rotating-priority selector: returns the first set request bit at or above
// `start`, wrapping; with start=0 it is a plain lowest-set-bit picker.
module isb_pfb_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // Scan from the farthest offset down so the nearest offset wins; N is a
  // power of two, so IW-bit addition wraps exactly mod N.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = start + IW'(k);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/isb_prefetch_buffer.sv
// Deduplicating prefetch buffer fed by the ISB prefetch stream.
// Optional statistics counters are enabled with the ISB_PFB_STATS_EN macro.
module isb_prefetch_buffer
  import isb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ISB_AW,
  parameter int DW    = ISB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pf_v,
  input  logic [AW-1:0] pf_addr,
  output logic          mem_req_v,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_resp_v,
  input  logic [AW-1:0] mem_resp_addr,
  input  logic [DW-1:0] mem_resp_data,
  input  logic          dmd_v,
  input  logic [AW-1:0] dmd_addr,
  output logic          dmd_hit,
  output logic [DW-1:0] dmd_data
`ifdef ISB_PFB_STATS_EN
  ,
  output logic [15:0]   stat_issued,
  output logic [15:0]   stat_hits,
  output logic [15:0]   stat_dropped
`endif
);

  localparam int IW = $clog2(DEPTH);

  entry_state_e  st     [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [IW-1:0] victim_ptr;

  logic [DEPTH-1:0] hit_vec, free_vec, ready_vec, queued_vec, dup_vec, resp_vec;
  logic [DW-1:0]    hit_data;

  // A demand hit frees its entry before this edge's allocation is decided,
  // so hit entries count as free and are excluded from the duplicate check.
  always_comb begin
    hit_vec    = '0;
    free_vec   = '0;
    ready_vec  = '0;
    queued_vec = '0;
    dup_vec    = '0;
    resp_vec   = '0;
    hit_data   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i]    = dmd_v && (st[i] == ST_READY) && (addr_q[i] == dmd_addr);
      free_vec[i]   = (st[i] == ST_INVALID) || hit_vec[i];
      ready_vec[i]  = (st[i] == ST_READY);
      queued_vec[i] = (st[i] == ST_QUEUED);
      dup_vec[i]    = !free_vec[i] && (addr_q[i] == pf_addr);
      resp_vec[i]   = mem_resp_v && (st[i] == ST_PENDING) && (addr_q[i] == mem_resp_addr);
      if (hit_vec[i]) hit_data = hit_data | data_q[i];
    end
  end

  logic          free_found, issue_found, vict_found;
  logic [IW-1:0] free_idx, issue_idx, vict_idx;

  isb_pfb_pick #(.N(DEPTH), .IW(IW)) u_free (
    .req(free_vec), .start('0), .found(free_found), .idx(free_idx)
  );

  isb_pfb_pick #(.N(DEPTH), .IW(IW)) u_issue (
    .req(queued_vec), .start('0), .found(issue_found), .idx(issue_idx)
  );

  isb_pfb_pick #(.N(DEPTH), .IW(IW)) u_victim (
    .req(ready_vec), .start(victim_ptr), .found(vict_found), .idx(vict_idx)
  );

  logic          dup, alloc, evict, drop, hs;
  logic [IW-1:0] alloc_idx;

  assign dup       = pf_v && (|dup_vec);
  assign alloc     = pf_v && !dup && (free_found || vict_found);
  assign evict     = alloc && !free_found;
  assign alloc_idx = free_found ? free_idx : vict_idx;
  assign drop      = pf_v && !alloc;

  assign mem_req_v    = issue_found;
  assign mem_req_addr = issue_found ? addr_q[issue_idx] : '0;
  assign hs           = issue_found && mem_req_ready;

  // Control: entry states, victim pointer and the registered demand result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= ST_INVALID;
      victim_ptr <= '0;
      dmd_hit    <= 1'b0;
      dmd_data   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hit_vec[i])                         st[i] <= ST_INVALID;
        if (hs && (issue_idx == IW'(i)))        st[i] <= ST_PENDING;
        if (resp_vec[i])                        st[i] <= ST_READY;
        if (alloc && (alloc_idx == IW'(i)))     st[i] <= ST_QUEUED;
      end
      if (evict) victim_ptr <= victim_ptr + 1'b1;
      dmd_hit  <= |hit_vec;
      dmd_data <= hit_data;
    end
  end

  // Payload registers carry no reset; their state field qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (resp_vec[i])                    data_q[i] <= mem_resp_data;
      if (alloc && (alloc_idx == IW'(i))) addr_q[i] <= pf_addr;
    end
  end

`ifdef ISB_PFB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_hits    <= '0;
      stat_dropped <= '0;
    end else begin
      if (hs)       stat_issued  <= sat_inc16(stat_issued);
      if (|hit_vec) stat_hits    <= sat_inc16(stat_hits);
      if (drop)     stat_dropped <= sat_inc16(stat_dropped);
    end
  end
`endif

endmodule

// File: tb/tb_isb_prefetch_buffer.sv
// Directed bench for isb_prefetch_buffer with an entry-level reference model;
// statistics checks are compiled in when ISB_PFB_STATS_EN is defined.
module tb_isb_prefetch_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pf_v;
  logic [15:0] pf_addr;
  logic        mem_req_v;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_v;
  logic [15:0] mem_resp_addr;
  logic [15:0] mem_resp_data;
  logic        dmd_v;
  logic [15:0] dmd_addr;
  logic        dmd_hit;
  logic [15:0] dmd_data;
`ifdef ISB_PFB_STATS_EN
  logic [15:0] stat_issued, stat_hits, stat_dropped;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  isb_prefetch_buffer #(.DEPTH(D), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pf_v(pf_v), .pf_addr(pf_addr),
    .mem_req_v(mem_req_v), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_v(mem_resp_v), .mem_resp_addr(mem_resp_addr), .mem_resp_data(mem_resp_data),
    .dmd_v(dmd_v), .dmd_addr(dmd_addr),
    .dmd_hit(dmd_hit), .dmd_data(dmd_data)
`ifdef ISB_PFB_STATS_EN
    , .stat_issued(stat_issued), .stat_hits(stat_hits), .stat_dropped(stat_dropped)
`endif
  );

  // Reference model: 0=empty, 1=waiting to issue, 2=in flight, 3=holding data.
  int          m_st   [D];
  logic [15:0] m_addr [D];
  logic [15:0] m_data [D];
  int          m_vptr;
  logic        m_hit;
  logic [15:0] m_dat;
  int          m_iss, m_hits, m_drop;

  always @(posedge clk) begin
    int h, iss, fr, j;
    int nst [D];
    bit dup;
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m_st[i] = 0;
      m_vptr = 0; m_hit = 1'b0; m_dat = 16'h0;
      m_iss = 0; m_hits = 0; m_drop = 0;
    end else begin
      h = -1;
      for (int i = 0; i < D; i++)
        if (dmd_v && m_st[i] == 3 && m_addr[i] == dmd_addr) h = i;
      m_hit = (h >= 0);
      m_dat = (h >= 0) ? m_data[h] : 16'h0;
      if (h >= 0 && m_hits < 65535) m_hits++;
      nst = m_st;
      if (h >= 0) nst[h] = 0;
      iss = -1;
      for (int i = 0; i < D; i++) if (iss < 0 && m_st[i] == 1) iss = i;
      if (iss >= 0 && mem_req_ready) begin
        nst[iss] = 2;
        if (m_iss < 65535) m_iss++;
      end
      for (int i = 0; i < D; i++)
        if (mem_resp_v && m_st[i] == 2 && m_addr[i] == mem_resp_addr) begin
          nst[i] = 3;
          m_data[i] = mem_resp_data;
        end
      if (pf_v) begin
        dup = 1'b0;
        for (int i = 0; i < D; i++)
          if (i != h && m_st[i] != 0 && m_addr[i] == pf_addr) dup = 1'b1;
        fr = -1;
        if (!dup) begin
          for (int i = 0; i < D; i++) if (fr < 0 && (m_st[i] == 0 || i == h)) fr = i;
          if (fr < 0) begin
            for (int k = 0; k < D; k++) begin
              j = (m_vptr + k) % D;
              if (fr < 0 && m_st[j] == 3) fr = j;
            end
            if (fr >= 0) m_vptr = (m_vptr + 1) % D;
          end
        end
        if (fr >= 0) begin
          nst[fr] = 1;
          m_addr[fr] = pf_addr;
        end else if (m_drop < 65535) m_drop++;
      end
      m_st = nst;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit          ev;
    logic [15:0] ea;
    ev = 1'b0; ea = 16'h0;
    for (int i = D - 1; i >= 0; i--) if (m_st[i] == 1) begin ev = 1'b1; ea = m_addr[i]; end
    chk("model mem_req_v", 32'(mem_req_v), 32'(ev));
    if (ev) chk("model mem_req_addr", 32'(mem_req_addr), 32'(ea));
    chk("model dmd_hit", 32'(dmd_hit), 32'(m_hit));
    chk("model dmd_data", 32'(dmd_data), 32'(m_dat));
`ifdef ISB_PFB_STATS_EN
    chk("model stat_issued", 32'(stat_issued), 32'(m_iss));
    chk("model stat_hits", 32'(stat_hits), 32'(m_hits));
    chk("model stat_dropped", 32'(stat_dropped), 32'(m_drop));
`endif
  endtask

  task automatic step(input bit pv, input logic [15:0] pa, input bit rdy,
                      input bit rv, input logic [15:0] ra, input logic [15:0] rd,
                      input bit dv, input logic [15:0] da);
    pf_v = pv; pf_addr = pa; mem_req_ready = rdy;
    mem_resp_v = rv; mem_resp_addr = ra; mem_resp_data = rd;
    dmd_v = dv; dmd_addr = da;
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 16'h0, rdy, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pf_v = 1'b0; pf_addr = '0; mem_req_ready = 1'b0;
    mem_resp_v = 1'b0; mem_resp_addr = '0; mem_resp_data = '0;
    dmd_v = 1'b0; dmd_addr = '0;
    idle(1'b0);
    idle(1'b0);
    chk("reset mem_req_v", 32'(mem_req_v), 32'h0);
    chk("reset dmd_hit", 32'(dmd_hit), 32'h0);
    chk("reset dmd_data", 32'(dmd_data), 32'h0);
    rst_n = 1'b1;

    // Basic prefetch, fill and demand hit.
    step(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("t1 req_v", 32'(mem_req_v), 32'h1);
    chk("t1 req_addr", 32'(mem_req_addr), 32'h0100);
    idle(1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0100);
    chk("t1 hit", 32'(dmd_hit), 32'h1);
    chk("t1 data", 32'(dmd_data), 32'hBEEF);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0100);
    chk("t1 second hit", 32'(dmd_hit), 32'h0);
    chk("t1 second data", 32'(dmd_data), 32'h0);

    // Back-to-back duplicate prefetch.
    do_reset();
    step(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    idle(1'b1);
    chk("t2 req_v idle", 32'(mem_req_v), 32'h0);
`ifdef ISB_PFB_STATS_EN
    chk("t2 stat_issued", 32'(stat_issued), 32'h1);
    chk("t2 stat_dropped", 32'(stat_dropped), 32'h1);
`endif

    // Stalled memory: fifth prefetch finds no victim; head address holds.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'(16'h0010 + k), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      chk("t3 hold addr", 32'(mem_req_addr), 32'h0010);
    end
    for (int k = 0; k < 4; k++) begin
      chk("t3 issue order", 32'(mem_req_addr), 32'(16'h0010 + k));
      idle(1'b1);
    end
    chk("t3 drained", 32'(mem_req_v), 32'h0);

    // Full of READY entries: eviction order follows the victim pointer.
    do_reset();
    for (int k = 0; k < 4; k++)
      step(1'b1, 16'(16'h0020 + k), 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    idle(1'b1);
    for (int k = 0; k < 4; k++)
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'(16'h0020 + k), 16'(16'h00A0 + k), 1'b0, 16'h0);
    step(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("t4 evict req", 32'(mem_req_addr), 32'h0050);
    step(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
    chk("t4 evicted0 miss", 32'(dmd_hit), 32'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0021);
    chk("t4 evicted1 miss", 32'(dmd_hit), 32'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0022);
    chk("t4 survivor hit", 32'(dmd_hit), 32'h1);
    chk("t4 survivor data", 32'(dmd_data), 32'h00A2);
    step(1'b1, 16'h0023, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0023);
    chk("t4 hit+alloc data", 32'(dmd_data), 32'h00A3);

    // Response and demand on the same edge.
    do_reset();
    step(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    idle(1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0030, 16'h1234, 1'b1, 16'h0030);
    chk("t5 same-edge miss", 32'(dmd_hit), 32'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0030);
    chk("t5 next hit", 32'(dmd_hit), 32'h1);
    chk("t5 next data", 32'(dmd_data), 32'h1234);

    // Reset while a request is in flight; its late response must be ignored.
    do_reset();
    step(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    idle(1'b1);
    do_reset();
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'h5555, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0040);
    chk("t6 hit", 32'(dmd_hit), 32'h0);
    chk("t6 data", 32'(dmd_data), 32'h0);
    chk("t6 req_v", 32'(mem_req_v), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
